// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the FIFO read port, the arbiter and its consumers.
// master = arbiter side, slave = FIFO/consumer side.
interface fifo_rd_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      req;
  logic                  f_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_r_en;
  logic [N_REQ-1:0]      gnt;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [ID_W-1:0]       dout_id;
  logic                  busy;

  modport master (
    input  req, f_empty, fifo_rdata,
    output fifo_r_en, gnt, dout, dout_valid, dout_id, busy
  );

  modport slave (
    output req, f_empty, fifo_rdata,
    input  fifo_r_en, gnt, dout, dout_valid, dout_id, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing the async FIFO read port among N_REQ consumers.
// Words come back one cycle after fifo_r_en, tagged with the owning consumer id.
//
//   state   | meaning
//   S_IDLE  | no grant; pick next requester starting at rr_ptr
//   S_BURST | gnt_id owns the read port until burst done, withdraw or starvation
module fifo_rd_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int STALL_MAX  = 16
) (
  input  logic                r_clk,
  input  logic                rrst,
  fifo_rd_arbiter_if.master   bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int SC_W = $clog2(STALL_MAX + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                state;
  logic [N_REQ-1:0]      gnt;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       rr_ptr;
  logic [BC_W-1:0]       beat_cnt;
  logic [SC_W-1:0]       stall_cnt;
  logic                  busy;
  logic                  dout_valid;
  logic [ID_W-1:0]       dout_id;
  logic [DATA_WIDTH-1:0] dout_hold;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_found;
  logic [ID_W-1:0]       idx;
  logic [ID_W-1:0]       next_ptr;
  logic                  own_req;
  logic                  rd_en;
  logic                  burst_done;
  logic                  starved;
  logic                  release_gnt;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign own_req     = bus.req[gnt_id];
  assign rd_en       = (state == S_BURST) && own_req && !bus.f_empty;
  assign burst_done  = rd_en && (beat_cnt == BC_W'(BURST_LEN - 1));
  assign starved     = bus.f_empty && (stall_cnt == SC_W'(STALL_MAX - 1));
  assign release_gnt = burst_done || !own_req || starved;
  assign next_ptr    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge r_clk) begin
    if (!rrst) begin
      state      <= S_IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout_id    <= '0;
      dout_hold  <= '0;
    end else begin
      dout_valid <= rd_en;
      dout_id    <= gnt_id;
      if (dout_valid) dout_hold <= bus.fifo_rdata;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state     <= S_BURST;
            gnt_id    <= pick_id;
            gnt       <= N_REQ'(1) << pick_id;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        S_BURST: begin
          if (release_gnt) begin
            state  <= S_IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end else if (rd_en) begin
            beat_cnt  <= beat_cnt + BC_W'(1);
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + SC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_r_en  = rd_en;
  assign bus.gnt        = gnt;
  assign bus.busy       = busy;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_id    = dout_id;
  assign bus.dout       = dout_valid ? bus.fifo_rdata : dout_hold;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios then random traffic, every cycle
// compared against a grant/word-count reference model and a sequential-word FIFO.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int SM = 16;

  logic r_clk = 1'b0;
  logic rrst  = 1'b0;
  always #5 r_clk = ~r_clk;

  fifo_rd_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_rd_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .STALL_MAX(SM)
  ) dut (
    .r_clk (r_clk),
    .rrst  (rrst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns the port, how many words/empty cycles so far.
  int          m_owner     = -1;
  int          m_words     = 0;
  int          m_empty_run = 0;
  int          m_start     = 0;
  bit          m_dv        = 1'b0;
  int          m_dv_id     = 0;
  logic [31:0] m_rdata     = '0;
  logic [31:0] m_hold      = '0;
  logic [31:0] next_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  task automatic release_grant();
    m_start = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic e, input logic rst_n);
    logic [N-1:0] exp_gnt;
    logic         exp_ren;
    bit           found;
    @(negedge r_clk);
    bus.req        = r;
    bus.f_empty    = e;
    rrst           = rst_n;
    bus.fifo_rdata = m_rdata;
    #1;
    exp_gnt = '0;
    exp_ren = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_ren = r[m_owner] && !e;
    end
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
    chk("fifo_r_en", 32'(bus.fifo_r_en), 32'(exp_ren));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    if (m_dv) begin
      chk("dout_id", 32'(bus.dout_id), 32'(m_dv_id));
      chk("dout", bus.dout, m_rdata);
    end else begin
      chk("dout_hold", bus.dout, m_hold);
    end

    // A read issued now pops the external FIFO whatever happens to the arbiter.
    if (!rst_n) begin
      m_owner = -1;
      m_start = 0;
      m_dv    = 1'b0;
      m_hold  = '0;
      if (exp_ren) begin
        m_rdata   = next_word;
        next_word = next_word + 1;
      end
    end else begin
      if (m_dv) m_hold = m_rdata;
      m_dv    = exp_ren;
      m_dv_id = m_owner;
      if (exp_ren) begin
        m_rdata   = next_word;
        next_word = next_word + 1;
      end
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && r[(m_start + k) % N]) begin
            found   = 1'b1;
            m_owner = (m_start + k) % N;
          end
        end
        m_words     = 0;
        m_empty_run = 0;
      end else if (!r[m_owner]) begin
        release_grant();
      end else if (exp_ren) begin
        m_words++;
        m_empty_run = 0;
        if (m_words == BL) release_grant();
      end else begin
        m_empty_run++;
        if (m_empty_run == SM) release_grant();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    int           empty_pct;
    next_word      = $urandom;
    bus.req        = '0;
    bus.f_empty    = 1'b1;
    bus.fifo_rdata = '0;
    rrst           = 1'b0;

    // reset with all requests asserted
    repeat (2) cycle(4'b1111, 1'b0, 1'b0);
    // round robin, FIFO full: grants 0,1,2,3,0
    repeat (45) cycle(4'b1111, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);
    // consumer 1 withdraws after three reads
    repeat (4) cycle(4'b0010, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);
    // consumer 2 granted next, starves on an empty FIFO, then 3 is granted
    repeat (18) cycle(4'b1111, 1'b1, 1'b1);
    repeat (3) cycle(4'b0000, 1'b0, 1'b1);
    // empty gap mid-burst
    for (int i = 0; i < 13; i++) cycle(4'b1111, (i == 4 || i == 5), 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);
    // reset after four reads, arbitration restarts at 0
    repeat (5) cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0);
    repeat (4) cycle(4'b1111, 1'b0, 1'b1);

    // random traffic
    rq        = 4'b1111;
    empty_pct = 20;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rq = N'($urandom);
      if (i % 60 == 0) empty_pct = $urandom_range(0, 100);
      cycle(rq, ($urandom_range(0, 99) < empty_pct), ($urandom_range(0, 249) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
